mem_stage: RTL and testbench
============================

# mem_stage

Fourth pipeline stage of the LoongArch 5-stage core: takes each executed instruction from the execute stage, waits for the data-SRAM response of loads and stores, and aligns and extends load data to 32 bits. Passes {pc, result, dest, gr_we} to write-back and publishes a forwarding/stall bus to decode. Holds one instruction plus one buffered SRAM response.

## Interface
- Parameters: none. All widths are fixed constants in the shared header.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ws_allowin  in  1  write-back can accept this cycle
- ms_allowin  out  1  this stage can accept; `!ms_valid || (ms_ready_go && ws_allowin)`
- es_to_ms_valid  in  1  execute-stage output valid
- es_to_ms_bus  in  82  bit fields:
  - [31:0] pc, [63:32] alu_result (the memory address for loads/stores)
  - [68:64] dest, [69] gr_we, [70] res_from_mem
  - [71] st_h, [72] st_b, [73] st_w
  - [74] ld_hu, [75] ld_h, [76] ld_bu, [77] ld_b, [78] ld_w
  - [79] mem_we, [81:80] addr[1:0]
- ms_to_ws_valid  out  1  `ms_valid && ms_ready_go`
- ms_to_ws_bus  out  70  [31:0] pc, [63:32] final_result, [68:64] dest, [69] gr_we
- ms_forward  out  40  [0] ms_valid, [1] gr_we, [6:2] dest, [38:7] final_result, [39] data_pending
- data_sram_data_ok  in  1  one-cycle pulse: response for the oldest outstanding request
- data_sram_rdata  in  32  load data; valid only while data_ok is high

## Operation
- need_mem = res_from_mem || mem_we. Every load and store issued a request in execute, so exactly one data_ok pulse belongs to it. Other instructions never wait.
- On `es_to_ms_valid && ms_allowin`, latch the bus into a register and set the state. The valid flag loads from es_to_ms_valid whenever ms_allowin is high.
- State machine, 2-bit:
  - EMPTY: `ms_valid = 0`.
  - WAIT: a memory instruction is held and no data_ok has arrived yet.
  - READY: the instruction can retire (either a non-memory instruction, or data is buffered).
- Transitions:
  - Accept with need_mem → WAIT. Accept without need_mem → READY. No accept and retire → EMPTY.
  - WAIT & data_ok & ws_allowin: retire in the same cycle, using the live rdata. Go to WAIT/READY/EMPTY depending on the new accept.
  - WAIT & data_ok & !ws_allowin: capture rdata into rdata_buf, → READY.
  - READY & ws_allowin: retire.
- ms_ready_go = (state==READY) || (state==WAIT && data_ok).
- Load data source is rdata_buf in READY, otherwise the live data_sram_rdata. Call it rd.
- Byte select by addr[1:0]: 0→rd[7:0], 1→rd[15:8], 2→rd[23:16], 3→rd[31:24]. Half select by addr[1]: 0→rd[15:0], 1→rd[31:16].
- Extension:
  - ld_b: sign-extend byte. ld_bu: zero-extend byte.
  - ld_h: sign-extend half. ld_hu: zero-extend half.
  - ld_w: rd unchanged.
- final_result = res_from_mem ? extended load : alu_result. Stores forward alu_result with gr_we = 0.
- data_pending = ms_valid && res_from_mem && !ms_ready_go. Decode must stall any consumer of dest while it is set.
- A data_ok pulse in EMPTY or READY is a protocol error: ignore it and flag it with a simulation assertion.

## Timing
- Reset values:
  - ms_valid = 0, state = EMPTY, ms_to_ws_valid = 0, ms_allowin = 1.
  - ms_forward[0] = 0, data_pending = 0.
  - rdata_buf = 0, bus register = 0.
- Reset mid-WAIT drops the instruction. The SRAM bridge shares this reset, so no stale data_ok follows.
- Non-memory instruction: ms_to_ws_valid rises the cycle after acceptance. Minimum occupancy is one cycle.
- Memory instruction:
  - ms_to_ws_valid is combinational from data_ok, so zero added latency when the response lands while the instruction is in WAIT.
  - The earliest data_ok is the cycle after acceptance.
- Back-to-back: retire and accept in the same cycle give full throughput.
- A buffered response persists across any number of ws_allowin-low cycles. rdata_buf is not overwritten, because no new data_ok can arrive for this instruction.

## Structure
- Bus widths ES_TO_MS_BUS_WD=82, MS_TO_WS_BUS_WD=70, MS_FORWARD_WD=40 and the state encodings live in the shared core header, next to the other stage-bus widths.
- One sub-module is natural: `load_align` (combinational; inputs rd, addr[1:0], the five ld_* flags; output the 32-bit extended value). It is reusable by a future uncached/AXI path.

## Test plan
- Non-memory op: pc=0x1c000010, alu_result=0x12345678, ws_allowin=1 → next cycle ms_to_ws_bus result 0x12345678, valid high for 1 cycle.
- ld_b at addr[1:0]=3, data_ok with rdata=0x80FF_0000 in the cycle after accept → result 0xFFFFFF80 in that same cycle. ld_bu with the same stimulus → 0x00000080.
- ld_h addr[1]=1, rdata=0x8001_1234, data_ok 3 cycles late → data_pending=1 for 3 cycles, ms_allowin=0, then result 0xFFFF8001.
- ld_w, data_ok with ws_allowin=0 for 4 cycles, rdata=0xDEADBEEF changed to 0 afterwards → result 0xDEADBEEF (from the buffer) when ws_allowin rises.
- Store st_w followed by an add back-to-back, data_ok 1 cycle after accept → store retires with gr_we=0, the add retires next cycle, no bubble.
- Reset asserted in WAIT → next cycle ms_valid=0, ms_allowin=1, ms_forward[0]=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared core header: stage-bus widths, memory-stage state encoding, bus layouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 82;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FORWARD_WD   = 40;

    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_WAIT  = 2'd1,
        MS_READY = 2'd2
    } ms_state_e;

    // Field order is MSB first, matching the execute-stage packing.
    typedef struct packed {
        logic [1:0]  addr_lo;
        logic        mem_we;
        logic        ld_w;
        logic        ld_b;
        logic        ld_bu;
        logic        ld_h;
        logic        ld_hu;
        logic        st_w;
        logic        st_b;
        logic        st_h;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half of a load word and sign/zero-extends it to 32 bits.
// Latency: combinational.
// Backpressure: none.
module load_align (
    input  logic [31:0] rd,
    input  logic [1:0]  addr,
    input  logic        ld_b,
    input  logic        ld_bu,
    input  logic        ld_h,
    input  logic        ld_hu,
    input  logic        ld_w,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rd[7:0];
            2'd1:    byte_sel = rd[15:8];
            2'd2:    byte_sel = rd[23:16];
            default: byte_sel = rd[31:24];
        endcase
        half_sel = addr[1] ? rd[31:16] : rd[15:0];
    end

    always_comb begin
        data = rd;
        if (ld_b)       data = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_bu) data = {24'd0, byte_sel};
        else if (ld_h)  data = {{16{half_sel[15]}}, half_sel};
        else if (ld_hu) data = {16'd0, half_sel};
        else if (ld_w)  data = rd;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: holds one instruction, waits for its data-SRAM response, aligns load data.
// Latency: 1 cycle for non-memory ops; memory ops retire in the data_ok cycle (zero added).
// Backpressure: ms_allowin low while waiting for data_ok or while write-back stalls a ready op.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FORWARD_WD-1:0]   ms_forward,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
);

    ms_state_e   state_q, state_d;
    es_to_ms_t   bus_q, bus_d;
    es_to_ms_t   es_bus;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        ms_valid;
    logic        ms_ready_go;
    logic        data_ok_in_wait;
    logic        need_mem;
    logic        data_pending;
    logic        gr_we_out;
    logic [31:0] rd;
    logic [31:0] ld_data;
    logic [31:0] final_result;
    logic        unused_st_flags;

    assign es_bus          = es_to_ms_bus;
    assign need_mem        = es_bus.res_from_mem || es_bus.mem_we;
    assign ms_valid        = (state_q != MS_EMPTY);
    assign data_ok_in_wait = (state_q == MS_WAIT) && data_sram_data_ok;
    assign ms_ready_go     = (state_q == MS_READY) || data_ok_in_wait;
    assign ms_allowin      = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid  = ms_valid && ms_ready_go;

    // ms_allowin low means a held op stays; only a WAIT op seeing data_ok moves (into the buffer).
    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        rdata_buf_d = rdata_buf_q;
        if (ms_allowin) begin
            if (es_to_ms_valid) begin
                bus_d   = es_bus;
                state_d = need_mem ? MS_WAIT : MS_READY;
            end else begin
                state_d = MS_EMPTY;
            end
        end else if (data_ok_in_wait) begin
            rdata_buf_d = data_sram_rdata;
            state_d     = MS_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MS_EMPTY;
            bus_q       <= '0;
            rdata_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    assign rd = (state_q == MS_READY) ? rdata_buf_q : data_sram_rdata;

    load_align u_load_align (
        .rd    (rd),
        .addr  (bus_q.addr_lo),
        .ld_b  (bus_q.ld_b),
        .ld_bu (bus_q.ld_bu),
        .ld_h  (bus_q.ld_h),
        .ld_hu (bus_q.ld_hu),
        .ld_w  (bus_q.ld_w),
        .data  (ld_data)
    );

    assign final_result = bus_q.res_from_mem ? ld_data : bus_q.alu_result;
    assign gr_we_out    = bus_q.gr_we && !bus_q.mem_we;
    assign data_pending = ms_valid && bus_q.res_from_mem && !ms_ready_go;

    assign ms_to_ws_bus = {gr_we_out, bus_q.dest, final_result, bus_q.pc};
    assign ms_forward   = {data_pending, final_result, bus_q.dest, gr_we_out, ms_valid};

    // Store width only matters to the SRAM request issued in execute.
    assign unused_st_flags = ^{bus_q.st_h, bus_q.st_b, bus_q.st_w};

    // Each response belongs to the op in WAIT; any other data_ok is a bridge bug.
    assert property (@(posedge clk) disable iff (reset)
        data_sram_data_ok |-> (state_q == MS_WAIT));

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: reset values, load-align vector table,
// multi-cycle corner sequences, then randomized traffic against a scoreboard model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [81:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [39:0] ms_forward;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_forward        (ms_forward),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    typedef enum int {OP_ALU, OP_LDB, OP_LDBU, OP_LDH, OP_LDHU, OP_LDW, OP_STB, OP_STH, OP_STW} op_e;

    typedef struct {
        string       name;
        op_e         op;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    function automatic bit is_store(input op_e op);
        return op inside {OP_STB, OP_STH, OP_STW};
    endfunction

    function automatic bit is_load(input op_e op);
        return op inside {OP_LDB, OP_LDBU, OP_LDH, OP_LDHU, OP_LDW};
    endfunction

    function automatic logic [81:0] mk_bus(input op_e op, input logic [31:0] pc,
                                           input logic [31:0] alu, input logic [4:0] dest);
        logic [81:0] b;
        b          = '0;
        b[31:0]    = pc;
        b[63:32]   = alu;
        b[68:64]   = dest;
        b[69]      = !is_store(op);
        b[70]      = is_load(op);
        b[71]      = (op == OP_STH);
        b[72]      = (op == OP_STB);
        b[73]      = (op == OP_STW);
        b[74]      = (op == OP_LDHU);
        b[75]      = (op == OP_LDH);
        b[76]      = (op == OP_LDBU);
        b[77]      = (op == OP_LDB);
        b[78]      = (op == OP_LDW);
        b[79]      = is_store(op);
        b[81:80]   = alu[1:0];
        return b;
    endfunction

    // Reference result: shift the word down to the addressed lane, mask, and
    // fold the value into the signed range for the sign-extending loads.
    function automatic logic [31:0] ref_result(input op_e op, input logic [31:0] alu,
                                               input logic [31:0] rdata);
        longint v;
        case (op)
            OP_LDB, OP_LDBU: begin
                v = (longint'(rdata) >> (8 * int'(alu[1:0]))) & 64'hFF;
                if (op == OP_LDB && v >= 128) v = v - 256;
            end
            OP_LDH, OP_LDHU: begin
                v = (longint'(rdata) >> (16 * int'(alu[1]))) & 64'hFFFF;
                if (op == OP_LDH && v >= 32768) v = v - 65536;
            end
            OP_LDW:  v = longint'(rdata);
            default: v = longint'(alu);
        endcase
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op for a single cycle; returns at the drive point after the accepting edge.
    task automatic issue(input logic [81:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        step();
        es_to_ms_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        issue(mk_bus(v.op, 32'h1c001000, v.alu, 5'd7));
        if (v.op != OP_ALU) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = v.rdata;
        end
        @(negedge clk);
        chk1({v.name, "/vld"}, ms_to_ws_valid, 1'b1);
        chk({v.name, "/res"}, ms_to_ws_bus[63:32], v.exp);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
    endtask

    vec_t vecs[$];

    // Scoreboard model state for the random phase.
    bit          held;
    bit          resp_done;
    op_e         h_op;
    logic [31:0] h_pc, h_alu, saved;
    logic [4:0]  h_dest;
    int          delay;

    initial begin
        op_e         n_op;
        logic [31:0] n_pc, n_alu, exp_res, data;
        logic [4:0]  n_dest;
        bit          need, ready, exp_allow;

        vecs.push_back('{"ldb_a3",   OP_LDB,  32'h1c000103, 32'h80FF0000, 32'hFFFFFF80});
        vecs.push_back('{"ldbu_a3",  OP_LDBU, 32'h1c000103, 32'h80FF0000, 32'h00000080});
        vecs.push_back('{"ldb_a0",   OP_LDB,  32'h1c000100, 32'h123456F0, 32'hFFFFFFF0});
        vecs.push_back('{"ldb_a1",   OP_LDB,  32'h1c000101, 32'h12345670, 32'h00000056});
        vecs.push_back('{"ldbu_a2",  OP_LDBU, 32'h1c000102, 32'h12AB5670, 32'h000000AB});
        vecs.push_back('{"ldb_a2",   OP_LDB,  32'h1c000102, 32'h12AB5670, 32'hFFFFFFAB});
        vecs.push_back('{"ldh_a0",   OP_LDH,  32'h1c000200, 32'h00008001, 32'hFFFF8001});
        vecs.push_back('{"ldh_a2",   OP_LDH,  32'h1c000202, 32'h7FFF0000, 32'h00007FFF});
        vecs.push_back('{"ldhu_a0",  OP_LDHU, 32'h1c000200, 32'h1234F00D, 32'h0000F00D});
        vecs.push_back('{"ldhu_a2",  OP_LDHU, 32'h1c000202, 32'hBEEF0000, 32'h0000BEEF});
        vecs.push_back('{"ldw",      OP_LDW,  32'h1c000300, 32'hCAFEBABE, 32'hCAFEBABE});
        vecs.push_back('{"alu",      OP_ALU,  32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5});
        vecs.push_back('{"stw",      OP_STW,  32'h00001000, 32'h5A5A5A5A, 32'h00001000});

        reset             = 1'b1;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst/allowin", ms_allowin, 1'b1);
        chk1("rst/ws_vld", ms_to_ws_valid, 1'b0);
        chk1("rst/fwd_vld", ms_forward[0], 1'b0);
        chk1("rst/pending", ms_forward[39], 1'b0);
        chk("rst/ws_res", ms_to_ws_bus[63:32], 32'h0);
        chk("rst/ws_pc", ms_to_ws_bus[31:0], 32'h0);
        step();
        reset = 1'b0;

        // Non-memory op: visible the cycle after acceptance, for exactly one cycle.
        issue(mk_bus(OP_ALU, 32'h1c000010, 32'h12345678, 5'd3));
        @(negedge clk);
        chk1("alu/vld", ms_to_ws_valid, 1'b1);
        chk("alu/res", ms_to_ws_bus[63:32], 32'h12345678);
        chk("alu/pc", ms_to_ws_bus[31:0], 32'h1c000010);
        step();
        @(negedge clk);
        chk1("alu/vld_drop", ms_to_ws_valid, 1'b0);
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // ld_h with a response three cycles late.
        issue(mk_bus(OP_LDH, 32'h1c000500, 32'h1c000202, 5'd9));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("ldh_late/pending", ms_forward[39], 1'b1);
            chk1("ldh_late/allowin", ms_allowin, 1'b0);
            chk1("ldh_late/vld", ms_to_ws_valid, 1'b0);
            step();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80011234;
        @(negedge clk);
        chk1("ldh_late/vld_ok", ms_to_ws_valid, 1'b1);
        chk1("ldh_late/pend_ok", ms_forward[39], 1'b0);
        chk("ldh_late/res", ms_to_ws_bus[63:32], 32'hFFFF8001);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;

        // ld_w response buffered while write-back stalls, live rdata then cleared.
        issue(mk_bus(OP_LDW, 32'h1c000600, 32'h1c000300, 5'd11));
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        @(negedge clk);
        chk1("buf/vld0", ms_to_ws_valid, 1'b1);
        chk1("buf/allowin0", ms_allowin, 1'b0);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("buf/vld_hold", ms_to_ws_valid, 1'b1);
            chk1("buf/pending", ms_forward[39], 1'b0);
            chk("buf/res_hold", ms_to_ws_bus[63:32], 32'hDEADBEEF);
            step();
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        chk1("buf/allowin", ms_allowin, 1'b1);
        chk("buf/res", ms_to_ws_bus[63:32], 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk1("buf/vld_drop", ms_to_ws_valid, 1'b0);
        step();

        // Store followed back-to-back by an add: no bubble between retirements.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(OP_STW, 32'h1c000400, 32'h00002000, 5'd0);
        step();
        es_to_ms_bus      = mk_bus(OP_ALU, 32'h1c000404, 32'h00000055, 5'd4);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h13572468;
        @(negedge clk);
        chk1("b2b/st_vld", ms_to_ws_valid, 1'b1);
        chk1("b2b/st_gr_we", ms_to_ws_bus[69], 1'b0);
        chk("b2b/st_res", ms_to_ws_bus[63:32], 32'h00002000);
        chk1("b2b/allowin", ms_allowin, 1'b1);
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk1("b2b/add_vld", ms_to_ws_valid, 1'b1);
        chk("b2b/add_pc", ms_to_ws_bus[31:0], 32'h1c000404);
        chk("b2b/add_res", ms_to_ws_bus[63:32], 32'h00000055);
        chk1("b2b/add_gr_we", ms_to_ws_bus[69], 1'b1);
        step();

        // Reset while a load waits drops it.
        issue(mk_bus(OP_LDW, 32'h1c000700, 32'h1c000800, 5'd12));
        @(negedge clk);
        chk1("rstw/pending", ms_forward[39], 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk1("rstw/fwd_vld", ms_forward[0], 1'b0);
        chk1("rstw/allowin", ms_allowin, 1'b1);
        chk1("rstw/ws_vld", ms_to_ws_valid, 1'b0);
        step();

        // Randomized traffic against the scoreboard model.
        held      = 1'b0;
        resp_done = 1'b0;
        delay     = 0;
        h_op      = OP_ALU;
        h_pc      = '0;
        h_alu     = '0;
        h_dest    = '0;
        saved     = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ws_allowin     = ($urandom_range(0, 3) != 0);
            es_to_ms_valid = $urandom_range(0, 1) != 0;
            n_op           = op_e'($urandom_range(0, 8));
            n_pc           = $urandom;
            n_alu          = $urandom;
            n_dest         = 5'($urandom_range(0, 31));
            es_to_ms_bus   = mk_bus(n_op, n_pc, n_alu, n_dest);
            need              = held && h_op != OP_ALU && !resp_done;
            data_sram_data_ok = need && delay == 0;
            data_sram_rdata   = $urandom;
            @(negedge clk);
            ready     = held && (h_op == OP_ALU || resp_done || data_sram_data_ok);
            exp_allow = !held || (ready && ws_allowin);
            chk1("rnd/ws_vld", ms_to_ws_valid, ready);
            chk1("rnd/allowin", ms_allowin, exp_allow);
            chk1("rnd/fwd_vld", ms_forward[0], held);
            chk1("rnd/pending", ms_forward[39], held && is_load(h_op) && !ready);
            if (ready) begin
                data    = resp_done ? saved : data_sram_rdata;
                exp_res = ref_result(h_op, h_alu, data);
                chk("rnd/pc", ms_to_ws_bus[31:0], h_pc);
                chk("rnd/res", ms_to_ws_bus[63:32], exp_res);
                chk("rnd/dest", {27'd0, ms_to_ws_bus[68:64]}, {27'd0, h_dest});
                chk1("rnd/gr_we", ms_to_ws_bus[69], !is_store(h_op));
                chk("rnd/fwd_res", ms_forward[38:7], exp_res);
            end
            if (need && data_sram_data_ok) begin
                resp_done = 1'b1;
                saved     = data_sram_rdata;
            end else if (need) begin
                delay--;
            end
            if (exp_allow) begin
                held = es_to_ms_valid;
                if (es_to_ms_valid) begin
                    h_op      = n_op;
                    h_pc      = n_pc;
                    h_alu     = n_alu;
                    h_dest    = n_dest;
                    resp_done = 1'b0;
                    delay     = $urandom_range(0, 3);
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
